// File: rtl/interfaz_uart_resultado_pkg.sv
// bip_pkg: constants and types shared by the halt-to-UART reporter.
//   BIP_N_OPCODE   - opcode field width of a BIP instruction
//   BIP_HLT_OPCODE - opcode value that halts the CPU
//   BYTE_W         - UART byte width
//   CYC_W          - width of the optional cycle counter
//   estado_e       - reporter FSM state encoding
package bip_pkg;

  localparam int          BIP_N_OPCODE   = 5;
  localparam int unsigned BIP_HLT_OPCODE = 0;
  localparam int          BYTE_W         = 8;
  localparam int          CYC_W          = 32;

  typedef enum logic [1:0] {
    EST_IDLE = 2'd0,
    EST_SEND = 2'd1,
    EST_WAIT = 2'd2,
    EST_DONE = 2'd3
  } estado_e;

endpackage

// File: rtl/interfaz_uart_resultado_if.sv
// UART TX handshake between the reporter (master) and the transmitter (slave).
//   tx_start - one-cycle pulse: transmit tx_data
//   tx_data  - byte to transmit
//   tx_done  - one-cycle pulse from the transmitter: byte finished
interface interfaz_uart_resultado_if;
  import bip_pkg::*;

  logic              tx_start;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_done;

  modport master (output tx_start, output tx_data, input tx_done);
  modport slave  (input tx_start, input tx_data, output tx_done);

endinterface

// File: rtl/interfaz_uart_resultado_serializador_bytes.sv
// serializador_bytes: shift register plus down-counting byte counter.
// Ports:
//   i_clock, i_reset - clock, synchronous active-high reset
//   i_load, i_dato   - load the whole word and the byte count N_BYTES
//   i_shift          - drop the current byte (shift right by one byte)
//   o_byte           - current byte, LSB first
//   o_ultimo         - the current byte is the last one
module serializador_bytes
  import bip_pkg::*;
#(
  parameter int N_BYTES = 2
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_load,
  input  logic [N_BYTES*BYTE_W-1:0] i_dato,
  input  logic                      i_shift,
  output logic [BYTE_W-1:0]         o_byte,
  output logic                      o_ultimo
);

  localparam int CNT_W = $clog2(N_BYTES + 1);

  logic [N_BYTES*BYTE_W-1:0] shreg;
  logic [CNT_W-1:0]          cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (i_load) begin
      shreg <= i_dato;
      cnt   <= CNT_W'(N_BYTES);
    end else if (i_shift && (cnt != '0)) begin
      shreg <= shreg >> BYTE_W;
      cnt   <= cnt - CNT_W'(1);
    end
  end

  assign o_byte   = shreg[BYTE_W-1:0];
  // terminal-count compare: the shift that consumes this byte empties the counter
  assign o_ultimo = (cnt == CNT_W'(1));

endmodule

// File: rtl/interfaz_uart_resultado.sv
// interfaz_uart_resultado: on a valid HLT instruction, freezes the CPU and
// sends the accumulator over UART, LSB first, then stays halted until reset.
// Optional build macro INTERFAZ_UART_CICLOS_EN appends a saturating 32-bit
// cycle count (frozen at the HLT edge) after the accumulator bytes.
// Ports:
//   i_clock, i_reset       - clock, synchronous active-high reset
//   i_instruccion, i_valid - instruction stream, opcode in the MSBs
//   i_acc                  - accumulator, captured on the HLT edge
//   tx                     - UART TX handshake (master side)
//   o_halt                 - CPU stall, sticky until reset
//   o_busy                 - bytes still pending
//
// state | meaning
// IDLE  | watching for HLT
// SEND  | tx_start pulse for the current byte
// WAIT  | waiting for tx_done of the current byte
// DONE  | everything sent, halted until reset
module interfaz_uart_resultado
  import bip_pkg::*;
#(
  parameter int                  N_INSTR    = 16,
  parameter int                  N_OPCODE   = BIP_N_OPCODE,
  parameter logic [N_OPCODE-1:0] HLT_OPCODE = N_OPCODE'(BIP_HLT_OPCODE),
  parameter int                  N_DATA     = 16
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [N_INSTR-1:0]       i_instruccion,
  input  logic                     i_valid,
  input  logic [N_DATA-1:0]        i_acc,
  interfaz_uart_resultado_if.master tx,
  output logic                     o_halt,
  output logic                     o_busy
);

  localparam logic [1:0] ST_IDLE = EST_IDLE;
  localparam logic [1:0] ST_SEND = EST_SEND;
  localparam logic [1:0] ST_WAIT = EST_WAIT;
  localparam logic [1:0] ST_DONE = EST_DONE;

  localparam int N_BYTES_ACC = N_DATA / BYTE_W;
`ifdef INTERFAZ_UART_CICLOS_EN
  localparam int N_BYTES = N_BYTES_ACC + CYC_W / BYTE_W;
`else
  localparam int N_BYTES = N_BYTES_ACC;
`endif
  localparam int N_BITS = N_BYTES * BYTE_W;

  logic [1:0]        estado;
  logic              hlt_det;
  logic              ser_load;
  logic              ser_shift;
  logic              ser_ultimo;
  logic [N_BITS-1:0] ser_dato;
  logic [BYTE_W-1:0] ser_byte;
  logic              unused_instr;

  assign hlt_det      = i_valid && (i_instruccion[N_INSTR-1 -: N_OPCODE] == HLT_OPCODE);
  assign unused_instr = ^i_instruccion[N_INSTR-N_OPCODE-1:0];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      estado <= ST_IDLE;
    end else begin
      case (estado)
        ST_IDLE: if (hlt_det) estado <= ST_SEND;
        ST_SEND: estado <= ST_WAIT;
        ST_WAIT: if (tx.tx_done) estado <= ser_ultimo ? ST_DONE : ST_SEND;
        default: estado <= ST_DONE;
      endcase
    end
  end

  assign ser_load  = (estado == ST_IDLE) && hlt_det;
  assign ser_shift = (estado == ST_WAIT) && tx.tx_done;

`ifdef INTERFAZ_UART_CICLOS_EN
  logic [CYC_W-1:0] ciclos;
  logic [CYC_W-1:0] ciclos_sig;

  assign ciclos_sig = (ciclos == '1) ? ciclos : ciclos + CYC_W'(1);

  // counts only while IDLE, so the value stops at the HLT edge; the load
  // takes ciclos_sig so the HLT edge itself is included in the count
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ciclos <= '0;
    end else if (estado == ST_IDLE) begin
      ciclos <= ciclos_sig;
    end
  end

  assign ser_dato = {ciclos_sig, i_acc};
`else
  assign ser_dato = i_acc;
`endif

  serializador_bytes #(
    .N_BYTES (N_BYTES)
  ) u_serializador (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_load   (ser_load),
    .i_dato   (ser_dato),
    .i_shift  (ser_shift),
    .o_byte   (ser_byte),
    .o_ultimo (ser_ultimo)
  );

  assign tx.tx_start = (estado == ST_SEND);
  assign tx.tx_data  = ser_byte;
  assign o_halt      = (estado != ST_IDLE);
  assign o_busy      = (estado == ST_SEND) || (estado == ST_WAIT);

endmodule

// File: tb/tb_interfaz_uart_resultado.sv
// Testbench for interfaz_uart_resultado (honours INTERFAZ_UART_CICLOS_EN).
module tb_interfaz_uart_resultado;

  localparam int N_DATA = 16;
  localparam int NB_ACC = N_DATA / 8;
`ifdef INTERFAZ_UART_CICLOS_EN
  localparam int NB = NB_ACC + 4;
`else
  localparam int NB = NB_ACC;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       instr;
  logic              valid;
  logic [N_DATA-1:0] acc;
  logic              halt;
  logic              busy;

  interfaz_uart_resultado_if uif ();

  interfaz_uart_resultado #(
    .N_INSTR    (16),
    .N_OPCODE   (5),
    .HLT_OPCODE (5'd0),
    .N_DATA     (N_DATA)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_instruccion (instr),
    .i_valid       (valid),
    .i_acc         (acc),
    .tx            (uif),
    .o_halt        (halt),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // reference model: halted flag, bytes not yet acknowledged, expected byte queue
  bit              m_halt;
  int              m_pending;
  bit              m_start_next;
  logic [7:0]      exp_q[$];
  logic [7:0]      got_q[$];
  longint unsigned m_cyc;
  // UART transmitter model
  int              cd;
  int              lat;
  bit              lat_rand;
  bit              spurious;
  int              starts;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    if (rst) m_cyc = 0;
    else if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
    check("tx_start", uif.tx_start, m_start_next);
    check("busy", busy, m_pending > 0);
    check("halt", halt, m_halt);
    if (m_start_next) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      check("tx_data", uif.tx_data, e);
    end
    uif.tx_done  = 1'b0;
    m_start_next = 1'b0;
    valid        = 1'b0;
    if (uif.tx_start === 1'b1) begin
      starts++;
      got_q.push_back(uif.tx_data);
      cd = lat_rand ? int'($urandom_range(2, 12)) : lat;
      uif.tx_done = spurious;
    end
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        cd = -1;
        uif.tx_done = 1'b1;
        if (m_pending > 0) begin
          m_pending--;
          m_start_next = (m_pending > 0);
        end
      end
    end
  endtask

  task automatic drive(input logic [4:0] op, input bit v, input logic [N_DATA-1:0] a);
    logic [63:0] val;
    instr = {op, 11'($urandom)};
    valid = v;
    acc   = a;
    if (v && (op == 5'd0) && !m_halt) begin
      m_halt       = 1'b1;
      m_pending    = NB;
      m_start_next = 1'b1;
      val = 64'(a);
`ifdef INTERFAZ_UART_CICLOS_EN
      val = val | (64'((m_cyc < 64'hFFFF_FFFF) ? m_cyc + 1 : m_cyc) << N_DATA);
`endif
      for (int i = 0; i < NB; i++) exp_q.push_back(8'(val >> (8 * i)));
    end
    tick();
  endtask

  task automatic do_reset(input int n);
    rst          = 1'b1;
    uif.tx_done  = 1'b0;
    valid        = 1'b0;
    cd           = -1;
    m_halt       = 1'b0;
    m_pending    = 0;
    m_start_next = 1'b0;
    exp_q.delete();
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while ((m_pending > 0) && (i < budget)) begin
      tick();
      i++;
    end
    check("drain_timeout", m_pending, 0);
  endtask

  initial begin
    rst = 1'b1; instr = '0; valid = 1'b0; acc = '0; uif.tx_done = 1'b0;
    cd = -1; lat = 10; lat_rand = 1'b0; spurious = 1'b0; starts = 0; m_cyc = 0;
    m_halt = 1'b0; m_pending = 0; m_start_next = 1'b0;

    // reset for 3 cycles, then idle
    do_reset(3);
    check("tx_data_reset", uif.tx_data, 8'h00);
    repeat (10) tick();
    check("no_start_idle", starts, 0);

    // HLT opcode without valid, then valid non-HLT opcode
    drive(5'd0, 1'b0, 16'hAAAA);
    drive(5'd1, 1'b1, 16'h5555);
    repeat (5) tick();
    check("no_start_non_hlt", starts, 0);

    // 0xBEEF with 10-cycle UART, extra HLT in WAIT and in DONE
    got_q.delete();
    drive(5'd0, 1'b1, 16'hBEEF);
    repeat (4) tick();
    drive(5'd0, 1'b1, 16'h1111);
    wait_done(80);
    tick();
    check("busy_after_last_done", busy, 1'b0);
    check("halt_after_last_done", halt, 1'b1);
    drive(5'd0, 1'b1, 16'h2222);
    repeat (20) tick();
    check("beef_starts", starts, NB);
    check("beef_byte0", got_q[0], 8'hEF);
    check("beef_byte1", got_q[1], 8'hBE);

    // reset in WAIT after the first byte started (with a done during SEND)
    do_reset(1);
    spurious = 1'b1;
    starts = 0;
    got_q.delete();
    drive(5'd0, 1'b1, 16'($urandom));
    repeat (3) tick();
    do_reset(1);
    check("halt_after_reset", halt, 1'b0);
    check("busy_after_reset", busy, 1'b0);
    check("data_after_reset", uif.tx_data, 8'h00);
    repeat (15) tick();
    check("starts_abandoned", starts, 1);

    // fresh HLT after the abandoned transfer
    spurious = 1'b0;
    starts = 0;
    got_q.delete();
    drive(5'd0, 1'b1, 16'h1234);
    wait_done(80);
    repeat (5) tick();
    check("r_starts", starts, NB);
    check("r_byte0", got_q[0], 8'h34);
    check("r_byte1", got_q[1], 8'h12);

    // randomized: noise instructions, random accumulator and UART latency
    lat_rand = 1'b1;
    for (int k = 0; k < 8; k++) begin
      do_reset(1 + int'($urandom_range(0, 2)));
      spurious = 1'($urandom_range(0, 1));
      starts = 0;
      repeat ($urandom_range(0, 5)) drive(5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)), 16'($urandom));
      drive(5'd0, 1'b0, 16'($urandom));
      drive(5'd0, 1'b1, 16'($urandom));
      wait_done(300);
      repeat (3) tick();
      check("rand_starts", starts, NB);
    end

`ifdef INTERFAZ_UART_CICLOS_EN
    // HLT on the 100th edge after reset release
    lat_rand = 1'b0;
    lat = 10;
    spurious = 1'b0;
    do_reset(2);
    starts = 0;
    got_q.delete();
    repeat (99) tick();
    drive(5'd0, 1'b1, 16'h005A);
    wait_done(300);
    repeat (3) tick();
    check("cyc_starts", starts, NB);
    check("cyc_byte_acc", got_q[0], 8'h5A);
    check("cyc_count", {got_q[5], got_q[4], got_q[3], got_q[2]}, 100);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
